// File: rtl/nor_result_checker.sv
// nor_result_checker: recomputes bitwise gate results, compares them against the unit under check, keeps statistics.
// Optional feature macro: CHECKER_HALT_EN (a mismatch parks the FSM in HALT until clear or reset).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   transaction handshake for op, A, B, result
//   clear                 synchronous clear of statistics and first-fail capture
//   chk_done / chk_fail   one-cycle compare pulse and its mismatch qualifier
//   pass_count/fail_count saturating compare counters
//   bad_op                sticky flag: reserved op 111 was received
//   ff_*                  first failing transaction capture
module nor_result_checker #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] result,
   input  logic             clear,
   output logic             chk_done,
   output logic             chk_fail,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             bad_op,
   output logic             ff_valid,
   output logic [2:0]       ff_op,
   output logic [WIDTH-1:0] ff_A,
   output logic [WIDTH-1:0] ff_B,
   output logic [WIDTH-1:0] ff_result,
   output logic [WIDTH-1:0] ff_expected
);
`ifdef CHECKER_HALT_EN
   typedef enum logic [1:0] {IDLE, CMP, HALT} state_t;
`else
   typedef enum logic [0:0] {IDLE, CMP} state_t;
`endif
   state_t state, state_next;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b, r_res, expected;
   logic             accept, rsv, mismatch;
   assign accept   = state == IDLE && in_ready && in_valid && !clear;
   assign rsv      = r_op == 3'b111;
   assign mismatch = !rsv && expected != r_res;
   always_comb begin
      expected = '0;
      case (r_op)
         3'b000:  expected = r_a & r_b;
         3'b001:  expected = r_a | r_b;
         3'b010:  expected = ~(r_a | r_b);
         3'b011:  expected = ~(r_a & r_b);
         3'b100:  expected = r_a ^ r_b;
         3'b101:  expected = ~(r_a ^ r_b);
         3'b110:  expected = ~r_a;
         default: expected = '0;
      endcase
   end
   always_comb begin
      state_next = state;
`ifdef CHECKER_HALT_EN
      state_next = clear ? IDLE : state == IDLE ? (accept ? CMP : IDLE) : state == CMP ? (mismatch ? HALT : IDLE) : state;
`else
      state_next = clear ? IDLE : state == IDLE ? (accept ? CMP : IDLE) : IDLE;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         chk_done    <= 1'b0;
         chk_fail    <= 1'b0;
         pass_count  <= '0;
         fail_count  <= '0;
         bad_op      <= 1'b0;
         ff_valid    <= 1'b0;
         ff_op       <= '0;
         ff_A        <= '0;
         ff_B        <= '0;
         ff_result   <= '0;
         ff_expected <= '0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
      end else begin
         state    <= state_next;
         // in_ready is registered so it tracks the state being entered
         in_ready <= state_next == IDLE;
         chk_done <= 1'b0;
         chk_fail <= 1'b0;
         if (accept) begin
            r_op  <= op;
            r_a   <= A;
            r_b   <= B;
            r_res <= result;
         end
         if (clear) begin
            pass_count  <= '0;
            fail_count  <= '0;
            bad_op      <= 1'b0;
            ff_valid    <= 1'b0;
            ff_op       <= '0;
            ff_A        <= '0;
            ff_B        <= '0;
            ff_result   <= '0;
            ff_expected <= '0;
         end else if (state == CMP) begin
            chk_done <= 1'b1;
            chk_fail <= mismatch;
            if (rsv)
               bad_op <= 1'b1;
            else if (mismatch) begin
               if (fail_count != '1)
                  fail_count <= fail_count + CNT_W'(1);
            end else if (pass_count != '1)
               pass_count <= pass_count + CNT_W'(1);
            if (mismatch && !ff_valid) begin
               ff_valid    <= 1'b1;
               ff_op       <= r_op;
               ff_A        <= r_a;
               ff_B        <= r_b;
               ff_result   <= r_res;
               ff_expected <= expected;
            end
         end
      end
   end
endmodule

// File: tb/tb_nor_result_checker.sv
// tb_nor_result_checker: randomized scoreboard bench for nor_result_checker.
module tb_nor_result_checker;
   localparam int W = 4;
   localparam int C = 8;
   localparam int SAT = (1 << C) - 1;
   logic clk = 0, rst_n = 0, in_valid = 0, clear = 0;
   logic [2:0] op = 0;
   logic [W-1:0] a = 0, b = 0, result = 0;
   logic in_ready, chk_done, chk_fail, bad_op, ff_valid;
   logic [C-1:0] pass_count, fail_count;
   logic [2:0] ff_op;
   logic [W-1:0] ff_A, ff_B, ff_result, ff_expected;
   nor_result_checker #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .A(a), .B(b), .result(result), .clear(clear),
      .chk_done(chk_done), .chk_fail(chk_fail),
      .pass_count(pass_count), .fail_count(fail_count), .bad_op(bad_op),
      .ff_valid(ff_valid), .ff_op(ff_op), .ff_A(ff_A), .ff_B(ff_B),
      .ff_result(ff_result), .ff_expected(ff_expected)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic fail;
      int pc, fc;
      logic bad, ffv;
      logic [2:0] fop;
      logic [W-1:0] fa, fb, fr, fe;
   } exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   int m_pc, m_fc;
   logic m_bad, m_ffv;
   logic [2:0] m_fop;
   logic [W-1:0] m_fa, m_fb, m_fr, m_fe;
   task automatic chk(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask
   // truth table per op, indexed by {a_bit, b_bit}
   function automatic logic [W-1:0] ref_calc(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
      logic [3:0] tt;
      logic [W-1:0] e;
      tt = o == 0 ? 4'b1000 : o == 1 ? 4'b1110 : o == 2 ? 4'b0001 : o == 3 ? 4'b0111 :
           o == 4 ? 4'b0110 : o == 5 ? 4'b1001 : 4'b0011;
      for (int i = 0; i < W; i++) e[i] = tt[{x[i], y[i]}];
      return e;
   endfunction
   task automatic model_reset();
      m_pc = 0; m_fc = 0; m_bad = 0; m_ffv = 0;
      m_fop = 0; m_fa = 0; m_fb = 0; m_fr = 0; m_fe = 0;
   endtask
   task automatic push(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] r);
      exp_t e;
      logic [W-1:0] v;
      logic bad_cmp;
      v = ref_calc(o, x, y);
      bad_cmp = o != 7 && v != r;
      if (o == 7) m_bad = 1;
      else if (bad_cmp) m_fc = m_fc < SAT ? m_fc + 1 : SAT;
      else m_pc = m_pc < SAT ? m_pc + 1 : SAT;
      if (bad_cmp && !m_ffv) begin
         m_ffv = 1; m_fop = o; m_fa = x; m_fb = y; m_fr = r; m_fe = v;
      end
      e.fail = bad_cmp; e.pc = m_pc; e.fc = m_fc; e.bad = m_bad; e.ffv = m_ffv;
      e.fop = m_fop; e.fa = m_fa; e.fb = m_fb; e.fr = m_fr; e.fe = m_fe;
      q.push_back(e);
   endtask
   // called at a negedge; leaves in_valid high and returns at the negedge after acceptance
   task automatic send(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] r, bit track = 1);
      int n;
      n = 0;
      op = o; a = x; b = y; result = r; in_valid = 1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      @(posedge clk);
      if (track) push(o, x, y, r);
      @(negedge clk);
      chk("busy_ready", int'(in_ready), 0);
      chk("busy_done", int'(chk_done), 0);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (chk_done) begin
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            chk("chk_fail", int'(chk_fail), int'(e.fail));
            chk("pass_count", int'(pass_count), e.pc);
            chk("fail_count", int'(fail_count), e.fc);
            chk("bad_op", int'(bad_op), int'(e.bad));
            chk("ff_valid", int'(ff_valid), int'(e.ffv));
            chk("ff_op", int'(ff_op), int'(e.fop));
            chk("ff_A", int'(ff_A), int'(e.fa));
            chk("ff_B", int'(ff_B), int'(e.fb));
            chk("ff_result", int'(ff_result), int'(e.fr));
            chk("ff_expected", int'(ff_expected), int'(e.fe));
         end
      end
   end
   initial begin
      logic [2:0] o;
      logic [W-1:0] x, y, r;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_chk_done", int'(chk_done), 0);
      chk("rst_pass", int'(pass_count), 0);
      chk("rst_fail", int'(fail_count), 0);
      chk("rst_bad_op", int'(bad_op), 0);
      chk("rst_ff_valid", int'(ff_valid), 0);
      rst_n = 1;
      @(negedge clk);
      chk("ready_after_rst", int'(in_ready), 1);
`ifdef CHECKER_HALT_EN
      send(3'b001, 4'b0011, 4'b0101, 4'b0000);
      in_valid = 0;
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         chk("halt_ready", int'(in_ready), 0);
         chk("halt_done", int'(chk_done), 0);
         @(negedge clk);
      end
      clear = 1;
      @(negedge clk);
      clear = 0;
      model_reset();
      chk("halt_clear_ready", int'(in_ready), 1);
      chk("halt_clear_fail", int'(fail_count), 0);
      chk("halt_clear_ffv", int'(ff_valid), 0);
`else
      send(3'b010, 4'b1001, 4'b1010, 4'b0100);
      send(3'b010, 4'b0000, 4'b1111, 4'b0000);
      send(3'b010, 4'b0000, 4'b0000, 4'b0000);
      send(3'b000, 4'b1111, 4'b1111, 4'b0000);
      in_valid = 0;
      @(negedge clk);
      chk("dir_ff_expected", int'(ff_expected), 15);
      chk("dir_ff_result", int'(ff_result), 0);
      chk("dir_fail_count", int'(fail_count), 2);
      chk("dir_pass_count", int'(pass_count), 2);
      clear = 1;
      @(negedge clk);
      clear = 0;
      model_reset();
      chk("clear_pass", int'(pass_count), 0);
      chk("clear_ffv", int'(ff_valid), 0);
      for (int i = 0; i < 260; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         if (i > 0) begin
            @(negedge clk);
            chk("b2b_ready", int'(in_ready), 1);
            chk("b2b_done", int'(chk_done), 1);
         end
         send(3'b010, x, y, ~(x | y));
      end
      in_valid = 0;
      @(negedge clk);
      chk("sat_pass", int'(pass_count), SAT);
      chk("sat_fail", int'(fail_count), 0);
      send(3'b111, W'($urandom), W'($urandom), W'($urandom));
      in_valid = 0;
      @(negedge clk);
      chk("rsv_bad_op", int'(bad_op), 1);
      chk("rsv_pass", int'(pass_count), SAT);
      op = 3'b010; a = 0; b = 0; result = 4'b1111; in_valid = 1; clear = 1;
      @(negedge clk);
      clear = 0;
      model_reset();
      chk("clrv_ready", int'(in_ready), 1);
      chk("clrv_done", int'(chk_done), 0);
      chk("clrv_pass", int'(pass_count), 0);
      chk("clrv_bad_op", int'(bad_op), 0);
      send(3'b010, 4'b0000, 4'b0000, 4'b1111);
      in_valid = 0;
      @(negedge clk);
      for (int i = 0; i < 150; i++) begin
         o = 3'($urandom_range(0, 7));
         x = W'($urandom);
         y = W'($urandom);
         r = $urandom_range(0, 3) == 0 ? W'($urandom) : ref_calc(o, x, y);
         send(o, x, y, r);
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 0;
            @(negedge clk);
         end
      end
      in_valid = 0;
      @(negedge clk);
`endif
      send(3'b010, 4'b0001, 4'b0010, 4'b0000, 0);
      in_valid = 0;
      rst_n = 0;
      #1;
      chk("mid_rst_ready", int'(in_ready), 0);
      chk("mid_rst_done", int'(chk_done), 0);
      chk("mid_rst_pass", int'(pass_count), 0);
      chk("mid_rst_fail", int'(fail_count), 0);
      chk("mid_rst_bad", int'(bad_op), 0);
      chk("mid_rst_ffv", int'(ff_valid), 0);
      model_reset();
      @(negedge clk);
      chk("mid_rst_done2", int'(chk_done), 0);
      rst_n = 1;
      chk("mid_rel_ready0", int'(in_ready), 0);
      @(negedge clk);
      chk("mid_rel_ready1", int'(in_ready), 1);
      repeat (2) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/nor_result_checker.md
Name: nor_result_checker

Overview:
Synthesizable response-side checker for the integer ALU logic units. It is the receiving end of the stimulus/response interface that feeds operand pairs into the bitwise gate units (NOR, AND, OR, ...).
- Accepts one (op, A, B, result) transaction per handshake.
- Recomputes the expected value, compares it against the returned result, and keeps pass/fail statistics.
- Captures the first failing transaction for debug.
- Sits after the gate units in the ALU self-test path.

Parameters:
WIDTH, 4, operand/result width in bits
CNT_W, 8, width of pass_count/fail_count (saturating)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  transaction present on op/A/B/result
in_ready  output  1  checker can accept; transfer when in_valid && in_ready
op  input  3  gate select: 000 AND, 001 OR, 010 NOR, 011 NAND, 100 XOR, 101 XNOR, 110 NOT A, 111 reserved
A  input  WIDTH  operand A
B  input  WIDTH  operand B
result  input  WIDTH  value produced by the unit under check
clear  input  1  synchronous clear of statistics and capture
chk_done  output  1  one-cycle pulse: a compare completed
chk_fail  output  1  qualifies chk_done: compare mismatched
pass_count  output  CNT_W  number of matching compares, saturates at all-ones
fail_count  output  CNT_W  number of mismatching compares, saturates at all-ones
bad_op  output  1  sticky: reserved op was received
ff_valid  output  1  first-fail capture registers hold data
ff_op  output  3  op of first failing transaction
ff_A  output  WIDTH  A of first failing transaction
ff_B  output  WIDTH  B of first failing transaction
ff_result  output  WIDTH  result of first failing transaction
ff_expected  output  WIDTH  expected value of first failing transaction

Behaviour:
- Reset (rst_n low, async): state=IDLE; every output register is 0, including in_ready, counters, flags and ff_*. in_ready rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, CMP, plus HALT when CHECKER_HALT_EN is defined.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register op/A/B/result, drop in_ready, go to CMP.
- CMP (exactly one cycle):
  - Compute expected from the registered operands per op. NOR = ~(A|B); NOT A ignores B. All results are truncated to WIDTH.
  - Compare expected against the registered result.
  - At the end of the cycle: chk_done=1 for one cycle; chk_fail=mismatch; increment pass_count or fail_count.
  - Return to IDLE with in_ready=1.
  - Throughput: 1 transaction per 2 cycles. Latency: accept edge to chk_done high = 1 cycle.
- Reserved op (111):
  - Neither counter changes.
  - bad_op is set (sticky).
  - chk_done pulses with chk_fail=0.
- First fail: on a mismatch while ff_valid=0, load ff_* and set ff_valid. Later fails do not overwrite the capture.
- Saturation: a counter at all-ones stays at all-ones; the other counter continues independently.
- clear has priority over everything except reset:
  - Zeros the counters, bad_op, ff_valid and ff_*.
  - If asserted in CMP, the in-flight compare is discarded (no chk_done, no count) and the FSM goes to IDLE.
  - If asserted in IDLE together with in_valid, the transaction is NOT accepted; in_ready stays 1 for the next cycle.
- in_valid while in_ready=0 is ignored. The source holds its data until accepted.
- Reset mid-CMP: the transaction is lost and all state returns to reset values.

Optional Feature:
CHECKER_HALT_EN:
- Defined: a mismatch in CMP sends the FSM to HALT instead of IDLE. In HALT, in_ready=0 and the first-fail capture is frozen; only clear (→IDLE) or reset exits.
- Undefined: the HALT state does not exist, and checking continues after failures.

Test Plan:
- op=010, A=1001, B=1010, result=0100 → chk_done with chk_fail=0; pass_count=1, fail_count=0.
- op=010, A=0000, B=1111, result=0000 → pass. Then op=010, A=0000, B=0000, result=0000 → fail; ff_valid=1, ff_expected=1111, ff_result=0000; a second failure leaves ff_* unchanged, fail_count=2.
- 260 back-to-back passing transactions with in_valid held high → pass_count=255 (saturated); in_ready toggles 1/0 each cycle; chk_done pulses every second cycle.
- op=111, any A/B → bad_op=1, counters unchanged. Then clear=1 together with in_valid in IDLE → counters 0, bad_op=0, transaction not accepted.
- Accept a transaction, then drop rst_n during CMP → all outputs 0 immediately; no chk_done; in_ready=1 one edge after release.
- With CHECKER_HALT_EN: a failing op=001, A=0011, B=0101, result=0000 → HALT, in_ready=0 for 10+ cycles; clear → IDLE, in_ready=1, fail_count=0.
